cnn_seq_ctrl: RTL and testbench
===============================

# cnn_seq_ctrl

Top-level sequencer for the CNN core. It accepts the 98 UART bytes of a 28x28 binary image and unpacks them bit by bit into the input RAM. It then fires the five layer engines (conv_0, max_0, conv_1, max_1, dense) in order through start/done handshakes, and hands the predicted class to the UART transmitter via trmt/tx_data. It sits between the UART receiver, the core and the UART transmitter, and replaces ad-hoc sequencing in the top level.

## Interface
- IMG_BYTES, 98, bytes per image; image bits = 8*IMG_BYTES (784)
- NUM_LAYERS, 5, layer engines sequenced in index order
- TIMEOUT, 65535, max cycles per layer before abort
- clk  in  1  system clock
- RST_n  in  1  asynchronous, active-low reset
- rx_rdy  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- ram_we  out  1  input-RAM write enable
- ram_waddr  out  10  input-RAM bit address (0..783)
- ram_wdata  out  1  input-RAM bit data
- layer_start  out  NUM_LAYERS  one-hot start pulse
- layer_done  in  NUM_LAYERS  one-cycle done pulses
- result  in  4  class index from dense, valid with layer_done[NUM_LAYERS-1]
- trmt  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit
- tx_done  in  1  transmitter finished
- busy  out  1  high in every state except LOAD
- ovf  out  1  sticky: a received byte was dropped
- tmo  out  1  sticky: a layer timed out

## Operation
- States: LOAD, UNPACK, RUN, SEND, WAIT_TX. Reset enters LOAD.
- LOAD:
  - A strobe with rx_rdy=1 latches rx_data into the shift register and enters UNPACK.
- UNPACK:
  - Writes 8 bits over 8 consecutive cycles, LSB first.
  - Each cycle: ram_waddr = 8*byte_cnt + k, ram_wdata = rx_data[k], k = 0..7.
  - After bit 7, byte_cnt increments.
  - If byte_cnt reaches IMG_BYTES: byte_cnt clears and the block enters RUN with layer index 0.
  - Otherwise: if the skid buffer is full, its byte is unpacked next (UNPACK again); if not, the block returns to LOAD.
- Skid buffer (1 byte):
  - An rx_rdy strobe during UNPACK fills the buffer if it is empty.
  - If the buffer is full, the byte is dropped and ovf sets.
- RUN:
  - Pulses layer_start[idx] for 1 cycle on entry to each layer, then waits for layer_done[idx].
  - layer_done bits other than idx are ignored.
  - On done with idx < NUM_LAYERS-1: idx increments and the next start pulses.
  - On done of the last layer: result is captured and the block enters SEND.
  - The cycle counter resets on each start. If the count reaches TIMEOUT: tmo sets, tx_data = 8'hFF, the block enters SEND.
- SEND: trmt = 1 for one cycle. tx_data = {4'h0, result}, or 8'hFF after a timeout. Then WAIT_TX.
- WAIT_TX: holds until tx_done, then enters LOAD. ovf clears on the WAIT_TX->LOAD transition; tmo does not.
- Bytes arriving in RUN, SEND or WAIT_TX are dropped and set ovf.
- Entering RUN with the skid buffer full flushes the buffer and sets ovf.

## Timing
- Reset values:
  - ram_we=0, ram_waddr=0, ram_wdata=0, layer_start=0, trmt=0, tx_data=0, busy=0, ovf=0, tmo=0.
  - byte_cnt=0, idx=0, skid buffer empty.
- All outputs are registered.
- Byte strobe at edge t (state LOAD): ram_we is high in cycles t+1..t+8, with addresses 8n..8n+7.
- Back-to-back bytes: a byte caught by the skid buffer begins writing at t+9 with no gap.
- Last bit of byte 97 written in cycle c: layer_start[0] pulses in cycle c+1.
- layer_done[i] seen at edge d: layer_start[i+1] pulses in cycle d+1.
- layer_done[4] at edge d: trmt pulses in cycle d+1, and tx_data is valid from that cycle until the next SEND.
- Timeout: tmo and trmt are both asserted TIMEOUT+1 cycles after the start pulse.
- rx_rdy and tx_done in the same cycle while in WAIT_TX: the byte is dropped (ovf sets) and the transition still occurs; ovf then clears on entering LOAD.
- Reset mid-operation: the state machine aborts immediately. No further start or trmt pulses occur, and partial RAM contents are left as they are.

## Test plan
- Image load:
  - Stimulus: 98 bytes, 50 cycles apart, from cnn_img_0.
  - Response: the input RAM matches all 784 image bits, and layer_start[0] pulses exactly once, 1 cycle after address 783 is written.
- Layer chain:
  - Stimulus: model engines answer done 10/20/30/40/50 cycles after their starts, with result=4'd7.
  - Response: the starts occur in order 0..4, trmt pulses once, tx_data=8'h07, busy=1 until tx_done.
- Back-to-back bytes:
  - Stimulus: two strobes 3 cycles apart; then three strobes within 8 cycles.
  - Response: the first case writes 16 consecutive addresses with ovf=0; the second case drops the third byte and sets ovf=1.
- Timeout:
  - Stimulus: TIMEOUT=100, and layer 2 never answers.
  - Response: tmo=1 and trmt with tx_data=8'hFF 101 cycles after layer_start[2]; no layer_start[3] occurs.
- Stray traffic:
  - Stimulus: a byte arrives during RUN; a layer_done[3] pulse arrives while idx=1.
  - Response: ovf=1, the stray done is ignored, and the sequence completes normally; ovf clears after tx_done.
- Reset mid-run:
  - Stimulus: drop RST_n while idx=2, then reload a full image.
  - Response: all outputs go to 0, and the second image completes with byte_cnt restarting at address 0.

Source files
------------

// File: rtl/cnn_seq_ctrl_if.sv
// Signal bundle between the CNN sequencer and its UART receiver, input RAM,
// layer engines and UART transmitter.
interface cnn_seq_ctrl_if #(
    parameter int NUM_LAYERS = 5
);
    logic                  rx_rdy;
    logic [7:0]            rx_data;
    logic                  ram_we;
    logic [9:0]            ram_waddr;
    logic                  ram_wdata;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [NUM_LAYERS-1:0] layer_done;
    logic [3:0]            result;
    logic                  trmt;
    logic [7:0]            tx_data;
    logic                  tx_done;
    logic                  busy;
    logic                  ovf;
    logic                  tmo;

    modport master (
        input  rx_rdy, rx_data, layer_done, result, tx_done,
        output ram_we, ram_waddr, ram_wdata, layer_start, trmt, tx_data,
               busy, ovf, tmo
    );

    modport slave (
        output rx_rdy, rx_data, layer_done, result, tx_done,
        input  ram_we, ram_waddr, ram_wdata, layer_start, trmt, tx_data,
               busy, ovf, tmo
    );
endinterface

// File: rtl/cnn_seq_ctrl.sv
// CNN core sequencer: unpacks received image bytes into the bit-wide input RAM,
// chains the layer engines through start/done, and sends the class byte.
module cnn_seq_ctrl #(
    parameter int IMG_BYTES  = 98,
    parameter int NUM_LAYERS = 5,
    parameter int TIMEOUT    = 65535
) (
    input  logic           clk,
    input  logic           RST_n,
    cnn_seq_ctrl_if.master bus
);
    localparam int BCW = $clog2(IMG_BYTES + 1);
    localparam int IW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0]        IMG_C    = BCW'(IMG_BYTES);
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_LAYERS - 1);
    localparam logic [CW-1:0]         TMO_C    = CW'(TIMEOUT);
    localparam logic [NUM_LAYERS-1:0] ONE_HOT0 = NUM_LAYERS'(1);

    typedef enum logic [2:0] {LOAD, UNPACK, RUN, SEND, WAIT_TX} state_t;

    state_t                state_q;
    logic [7:0]            shift_q;
    logic [2:0]            bit_q;
    logic [BCW-1:0]        byte_cnt_q;
    logic [7:0]            skid_q;
    logic                  skid_vld_q;
    logic [IW-1:0]         idx_q;
    logic [CW-1:0]         cnt_q;
    logic                  ram_we_q;
    logic [9:0]            ram_waddr_q;
    logic                  ram_wdata_q;
    logic [NUM_LAYERS-1:0] start_q;
    logic                  trmt_q;
    logic [7:0]            tx_data_q;
    logic                  busy_q;
    logic                  ovf_q;
    logic                  tmo_q;

    logic [2:0]     bit_nxt;
    logic [BCW-1:0] byte_nxt;
    logic [IW-1:0]  idx_nxt;
    logic [7:0]     next_byte;

    assign bit_nxt   = bit_q + 3'd1;
    assign byte_nxt  = byte_cnt_q + BCW'(1);
    assign idx_nxt   = idx_q + IW'(1);
    // A parked skid byte always goes ahead of a byte arriving this cycle.
    assign next_byte = skid_vld_q ? skid_q : bus.rx_data;

    function automatic logic [9:0] addr_of(input logic [BCW-1:0] b);
        return 10'(b) << 3;
    endfunction

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= LOAD;
            shift_q     <= '0;
            bit_q       <= '0;
            byte_cnt_q  <= '0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= 1'b0;
            start_q     <= '0;
            trmt_q      <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            start_q <= '0;
            trmt_q  <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (bus.rx_rdy) begin
                        shift_q     <= bus.rx_data;
                        bit_q       <= '0;
                        ram_we_q    <= 1'b1;
                        ram_waddr_q <= addr_of(byte_cnt_q);
                        ram_wdata_q <= bus.rx_data[0];
                        busy_q      <= 1'b1;
                        state_q     <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (bit_q != 3'd7) begin
                        bit_q       <= bit_nxt;
                        ram_waddr_q <= ram_waddr_q + 10'd1;
                        ram_wdata_q <= shift_q[bit_nxt];
                        if (bus.rx_rdy) begin
                            if (skid_vld_q) ovf_q <= 1'b1;
                            else begin
                                skid_q     <= bus.rx_data;
                                skid_vld_q <= 1'b1;
                            end
                        end
                    end else if (byte_nxt == IMG_C) begin
                        // Image complete; anything still queued is discarded.
                        byte_cnt_q <= '0;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        start_q    <= ONE_HOT0;
                        ram_we_q   <= 1'b0;
                        skid_vld_q <= 1'b0;
                        if (skid_vld_q || bus.rx_rdy) ovf_q <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        byte_cnt_q <= byte_nxt;
                        if (skid_vld_q || bus.rx_rdy) begin
                            shift_q     <= next_byte;
                            bit_q       <= '0;
                            ram_waddr_q <= addr_of(byte_nxt);
                            ram_wdata_q <= next_byte[0];
                            skid_vld_q  <= 1'b0;
                            if (skid_vld_q && bus.rx_rdy) ovf_q <= 1'b1;
                        end else begin
                            ram_we_q <= 1'b0;
                            busy_q   <= 1'b0;
                            state_q  <= LOAD;
                        end
                    end
                end
                RUN: begin
                    if (bus.rx_rdy) ovf_q <= 1'b1;
                    if (bus.layer_done[idx_q]) begin
                        if (idx_q == LAST_IDX) begin
                            trmt_q    <= 1'b1;
                            tx_data_q <= {4'h0, bus.result};
                            state_q   <= SEND;
                        end else begin
                            idx_q   <= idx_nxt;
                            start_q <= ONE_HOT0 << idx_nxt;
                            cnt_q   <= '0;
                        end
                    end else if (cnt_q == TMO_C) begin
                        tmo_q     <= 1'b1;
                        trmt_q    <= 1'b1;
                        tx_data_q <= 8'hFF;
                        state_q   <= SEND;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SEND: begin
                    if (bus.rx_rdy) ovf_q <= 1'b1;
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    // The clear on leaving wins over a byte dropped in the same cycle.
                    if (bus.tx_done) begin
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= LOAD;
                    end else if (bus.rx_rdy) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.ram_we      = ram_we_q;
    assign bus.ram_waddr   = ram_waddr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.layer_start = start_q;
    assign bus.trmt        = trmt_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.ovf         = ovf_q;
    assign bus.tmo         = tmo_q;
endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Directed bench for cnn_seq_ctrl: image load, layer chain, skid buffer,
// timeout, stray traffic and mid-run reset.
module tb_cnn_seq_ctrl;
    localparam int IMG = 98;
    localparam int NL  = 5;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnn_seq_ctrl_if #(.NUM_LAYERS(NL)) bus();
    cnn_seq_ctrl #(.IMG_BYTES(IMG), .NUM_LAYERS(NL), .TIMEOUT(TMO)) dut (
        .clk(clk), .RST_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation side: RAM image, write timing, start/trmt events
    logic       mem [0:8*IMG-1];
    int         wr_cyc [0:8*IMG-1];
    int         wr_tot = 0;
    int         last_wa = 0;
    int         st_tot [NL] = '{default: 0};
    int         st_cyc [NL] = '{default: 0};
    int         st_log [$];
    int         tr_tot = 0;
    int         tr_cyc = 0;
    logic [7:0] tr_data = 8'h00;

    always @(negedge clk) begin
        if (bus.ram_we && bus.ram_waddr < 10'(8*IMG)) begin
            mem[bus.ram_waddr]    = bus.ram_wdata;
            wr_cyc[bus.ram_waddr] = cyc;
            wr_tot++;
            last_wa = int'(bus.ram_waddr);
        end
        for (int i = 0; i < NL; i++)
            if (bus.layer_start[i]) begin
                st_tot[i]++;
                st_cyc[i] = cyc;
                st_log.push_back(i);
            end
        if (bus.trmt) begin
            tr_tot++;
            tr_cyc  = cyc;
            tr_data = bus.tx_data;
        end
    end

    int sb [NL];
    int lb, tb0, wb;

    task automatic snap();
        for (int i = 0; i < NL; i++) sb[i] = st_tot[i];
        lb  = st_log.size();
        tb0 = tr_tot;
        wb  = wr_tot;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] img(input int seed, input int i);
        return 8'((i * 37 + seed * 53 + 5) ^ (i >> 2));
    endfunction

    task automatic send(input logic [7:0] b, output int e);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        tick();
        e = cyc;
        bus.rx_rdy = 1'b0;
    endtask

    task automatic load(input int seed, input int from, input int gap);
        int e;
        for (int i = from; i < IMG; i++) begin
            send(img(seed, i), e);
            repeat (gap - 1) tick();
        end
    endtask

    task automatic chk_img(input int seed, input string tag);
        int errs = 0;
        logic [7:0] bv;
        for (int a = 0; a < 8 * IMG; a++) begin
            bv = img(seed, a / 8);
            if (mem[a] !== bv[a % 8]) errs++;
        end
        chk(tag, errs, 0);
    endtask

    task automatic chk_bytes(input int a0, input logic [7:0] b0, input logic [7:0] b1,
                             input string tag);
        int errs = 0;
        logic [15:0] w;
        w = {b1, b0};
        for (int k = 0; k < 16; k++) if (mem[a0 + k] !== w[k]) errs++;
        chk(tag, errs, 0);
    endtask

    task automatic wait_start(input int i);
        int n = 0;
        while (st_tot[i] == sb[i] && n < 400) begin
            tick();
            n++;
        end
        chk($sformatf("start%0d_seen", i), 32'(st_tot[i] != sb[i]), 1);
    endtask

    task automatic done(input int i, input logic [3:0] r, output int e);
        bus.layer_done = NL'(1) << i;
        bus.result     = r;
        tick();
        e = cyc;
        bus.layer_done = '0;
    endtask

    task automatic step(input int i, input logic [3:0] r, input int d);
        int e;
        wait_start(i);
        repeat (d) tick();
        done(i, r, e);
    endtask

    task automatic tx_ack();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ram_we"},    bus.ram_we, 0);
        chk({pfx, "_ram_waddr"}, bus.ram_waddr, 0);
        chk({pfx, "_ram_wdata"}, bus.ram_wdata, 0);
        chk({pfx, "_start"},     bus.layer_start, 0);
        chk({pfx, "_trmt"},      bus.trmt, 0);
        chk({pfx, "_tx_data"},   bus.tx_data, 0);
        chk({pfx, "_busy"},      bus.busy, 0);
        chk({pfx, "_ovf"},       bus.ovf, 0);
        chk({pfx, "_tmo"},       bus.tmo, 0);
    endtask

    initial begin
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, e0, e1, e2;
        bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.layer_done = '0;
        bus.result = '0;   bus.tx_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Image load, 50 cycles per byte
        snap();
        send(img(1, 0), e0);
        repeat (49) tick();
        load(1, 1, 50);
        chk("b0_first_wr", wr_cyc[0], e0);
        chk("b0_last_wr",  wr_cyc[7], e0 + 7);
        wait_start(0);
        chk_img(1, "img1_bits");
        chk("img1_wr_count", wr_tot - wb, 8 * IMG);
        chk("img1_last_addr", last_wa, 783);
        chk("start0_once", st_tot[0] - sb[0], 1);
        chk("start0_lat", st_cyc[0] - wr_cyc[783], 1);
        chk("img1_ovf", bus.ovf, 0);

        // Layer chain 10/20/30/40/50, class 7
        for (int i = 0; i < NL; i++) begin
            wait_start(i);
            if (i > 0) chk($sformatf("start%0d_lat", i), st_cyc[i], e);
            chk($sformatf("busy_l%0d", i), bus.busy, 1);
            repeat (10 * (i + 1) - 1) tick();
            done(i, 4'd7, e);
        end
        tick(); tick();
        chk("chain_trmt_lat", tr_cyc, e);
        chk("chain_trmt_once", tr_tot - tb0, 1);
        chk("chain_tx_data", tr_data, 8'h07);
        chk("chain_start_cnt", st_log.size() - lb, NL);
        for (int i = 0; i < NL; i++) chk($sformatf("chain_order%0d", i), st_log[lb + i], i);
        repeat (20) tick();
        chk("chain_busy_wait", bus.busy, 1);
        chk("chain_trmt_still_once", tr_tot - tb0, 1);
        tx_ack();
        chk("chain_busy_done", bus.busy, 0);
        chk("chain_tx_hold", bus.tx_data, 8'h07);

        // Back-to-back bytes through the skid buffer
        snap();
        send(8'hA5, e1);
        repeat (2) tick();
        send(8'h3C, e2);
        repeat (20) tick();
        chk("b2b_wr_count", wr_tot - wb, 16);
        chk("b2b_gap", e2 - e1, 3);
        chk("b2b_contig", wr_cyc[15] - wr_cyc[0], 15);
        chk("b2b_skid_start", wr_cyc[8], e1 + 8);
        chk_bytes(0, 8'hA5, 8'h3C, "b2b_bits");
        chk("b2b_ovf", bus.ovf, 0);
        send(8'hF0, e);
        repeat (2) tick();
        send(8'h0F, e);
        repeat (2) tick();
        send(8'h99, e);
        repeat (20) tick();
        chk("tri_wr_count", wr_tot - wb, 32);
        chk_bytes(16, 8'hF0, 8'h0F, "tri_bits");
        chk("tri_ovf", bus.ovf, 1);
        chk("tri_busy", bus.busy, 0);

        // Finish the image, then layer 2 never answers
        snap();
        load(5, 4, 10);
        step(0, 4'd1, 5);
        step(1, 4'd1, 5);
        wait_start(2);
        begin
            int n = 0;
            while (tr_tot == tb0 && n < 300) begin tick(); n++; end
        end
        chk("tmo_trmt_seen", tr_tot - tb0, 1);
        chk("tmo_lat", tr_cyc - st_cyc[2], TMO + 1);
        chk("tmo_tx_data", tr_data, 8'hFF);
        chk("tmo_flag", bus.tmo, 1);
        repeat (10) tick();
        chk("tmo_no_start3", st_tot[3] - sb[3], 0);
        chk("tmo_ovf_sticky", bus.ovf, 1);
        tx_ack();
        chk("tmo_ovf_clr", bus.ovf, 0);
        chk("tmo_tmo_sticky", bus.tmo, 1);
        chk("tmo_busy", bus.busy, 0);

        // Stray byte and stray done during RUN
        snap();
        load(2, 0, 10);
        chk_img(2, "img2_bits");
        step(0, 4'd0, 5);
        wait_start(1);
        done(3, 4'd0, e);
        repeat (5) tick();
        chk("stray_done_s2", st_tot[2] - sb[2], 0);
        chk("stray_done_s4", st_tot[4] - sb[4], 0);
        send(8'h55, e);
        tick();
        chk("stray_byte_ovf", bus.ovf, 1);
        chk("stray_byte_nowr", wr_tot - wb, 8 * IMG);
        done(1, 4'd0, e);
        step(2, 4'd0, 4);
        step(3, 4'd0, 4);
        step(4, 4'd3, 4);
        tick(); tick();
        chk("stray_trmt_once", tr_tot - tb0, 1);
        chk("stray_tx_data", tr_data, 8'h03);
        chk("stray_start_cnt", st_log.size() - lb, NL);
        bus.rx_rdy = 1'b1; bus.rx_data = 8'h77; bus.tx_done = 1'b1;
        tick();
        bus.rx_rdy = 1'b0; bus.tx_done = 1'b0;
        tick();
        chk("rxtx_ovf_clr", bus.ovf, 0);
        chk("rxtx_busy", bus.busy, 0);
        chk("rxtx_nowr", wr_tot - wb, 8 * IMG);

        // Reset while layer 2 is running, then a fresh image
        snap();
        load(3, 0, 10);
        step(0, 4'd0, 3);
        step(1, 4'd0, 3);
        wait_start(2);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        bus.layer_done = 5'b00100;
        tick();
        bus.layer_done = '0;
        repeat (20) tick();
        chk("midrst_no_s3", st_tot[3] - sb[3], 0);
        chk("midrst_no_trmt", tr_tot - tb0, 0);
        rst_n = 1'b1;
        tick();
        snap();
        send(img(4, 0), e);
        repeat (9) tick();
        chk("reload_addr0_cyc", wr_cyc[0], e);
        load(4, 1, 10);
        chk_img(4, "img4_bits");
        step(0, 4'd0, 3);
        step(1, 4'd0, 3);
        step(2, 4'd0, 3);
        step(3, 4'd0, 3);
        step(4, 4'd9, 3);
        tick(); tick();
        chk("reload_trmt_once", tr_tot - tb0, 1);
        chk("reload_tx_data", tr_data, 8'h09);
        tx_ack();
        chk("reload_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
